// File: rtl/apb_master_port_if.sv
// Bundles the CPU request/response handshake and the APB bus signals of apb_master_port.
// The master modport is the requester's view; the slave modport is the CPU/bus-side view.
interface apb_master_port_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [15:0]          req_addr;
  logic [15:0]          req_wdata;
  logic                 rsp_valid;
  logic [15:0]          rsp_rdata;
  logic                 rsp_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [15:0]          paddr;
  logic [15:0]          pwdata;
  logic [15:0]          prdata;
  logic                 pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, err_count,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_count,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_port.sv
// Single-beat APB requester: CPU load/store -> SETUP/ACCESS, one-cycle response pulse,
// and a bounded ACCESS wait that aborts with an error for regions that never answer.
module apb_master_port #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  apb_master_port_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);

  state_t               state, next_state;
  logic                 accept, done_ok, done_to;
  logic [7:0]           wait_cnt;
  logic [7:0]           wait_next;
  logic                 psel_q, penable_q, pwrite_q;
  logic [15:0]          paddr_q, pwdata_q;
  logic                 rsp_valid_q, rsp_err_q;
  logic [15:0]          rsp_rdata_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  assign wait_next = 8'(wait_cnt + 8'd1);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.req_valid && !reset;
        if (accept) next_state = SETUP;
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        // A ready slave in the last allowed cycle still completes normally.
        if (bus.pready) begin
          done_ok    = 1'b1;
          next_state = IDLE;
        end else if (wait_next == TIMEOUT_LAST) begin
          done_to    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 16'h0000;
      pwdata_q    <= 16'h0000;
      wait_cnt    <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      err_cnt_q   <= '0;
    end else begin
      // Bus strobes are registered from the next state so they line up with it.
      psel_q      <= (next_state != IDLE);
      penable_q   <= (next_state == ACCESS);
      rsp_valid_q <= done_ok || done_to;
      rsp_err_q   <= done_to;
      if (accept) begin
        pwrite_q <= bus.req_write;
        paddr_q  <= bus.req_addr;
        pwdata_q <= bus.req_wdata;
        wait_cnt <= 8'd0;
      end else if (state == ACCESS && !bus.pready) begin
        wait_cnt <= wait_next;
      end
      if (done_ok)      rsp_rdata_q <= pwrite_q ? 16'h0000 : bus.prdata;
      else if (done_to) rsp_rdata_q <= 16'h0000;
      if (done_to && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_apb_master_port.sv
// Self-checking bench for apb_master_port: vector table plus scoreboard queue,
// a wait-state slave model, and hand-written back-to-back and mid-transfer reset sequences.
module tb_apb_master_port;
  localparam int TO = 16;

  logic clk;
  logic reset;

  apb_master_port_if #(.ERR_CNT_W(8)) bus ();

  apb_master_port #(.TIMEOUT_CYCLES(TO), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;     // slave read data returned when pready rises
    int          waits;     // ACCESS cycles before pready; >= TO means timeout
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests, fails;
  int          cyc;
  int          psel_cnt;
  int          model_err;
  int          cur_waits;
  int          acc_n;
  logic [15:0] cur_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: pready after cur_waits ACCESS cycles, random pready/prdata outside ACCESS.
  initial begin
    acc_n      = 0;
    bus.pready = 1'b0;
    bus.prdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.psel && bus.penable) begin
        if (acc_n == cur_waits) begin
          bus.pready = 1'b1;
          bus.prdata = cur_rdata;
        end else begin
          bus.pready = 1'b0;
          bus.prdata = 16'($urandom);
        end
        acc_n++;
      end else begin
        acc_n      = 0;
        bus.pready = 1'($urandom);
        bus.prdata = 16'($urandom);
      end
    end
  end

  // Monitor: bus stability while selected, and scoreboard comparison on each response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.psel) begin
          psel_cnt++;
          if (exp_q.size() == 0) begin
            check("psel_idle", {31'd0, bus.psel}, 32'd0);
          end else begin
            check("paddr_hold", {16'd0, bus.paddr}, {16'd0, exp_q[0].addr});
            check("pwrite_hold", {31'd0, bus.pwrite}, {31'd0, exp_q[0].write});
            if (exp_q[0].write)
              check("pwdata_hold", {16'd0, bus.pwdata}, {16'd0, exp_q[0].wdata});
            check("penable_phase", {31'd0, bus.penable}, (psel_cnt > 1) ? 32'd1 : 32'd0);
          end
        end
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.err && model_err < 255) model_err++;
            check("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, e.rdata});
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            check("err_count", {24'd0, bus.err_count}, model_err);
            check("rsp_latency", cyc - e.acc_cyc, e.lat);
            check("psel_cycles", psel_cnt, e.lat);
            check("psel_low_at_rsp", {31'd0, bus.psel}, 32'd0);
          end
          psel_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input vec_t v, output int acc);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", {31'd0, bus.req_ready}, 32'd1);
    e.write   = v.write;
    e.addr    = v.addr;
    e.wdata   = v.wdata;
    e.err     = v.exp_err;
    e.rdata   = v.exp_rdata;
    e.lat     = v.exp_err ? TO + 1 : v.waits + 2;
    e.acc_cyc = cyc + 1;
    acc       = cyc + 1;
    exp_q.push_back(e);
    cur_waits = v.waits;
    cur_rdata = v.rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait_bound", exp_q.size(), 0);
  endtask

  vec_t vecs[7];
  vec_t bb[4];
  vec_t v;
  int   acc_t[4];
  int   acc_dummy;

  initial begin
    tests = 0; fails = 0; psel_cnt = 0; model_err = 0;
    cur_waits = 0; cur_rdata = 16'h0000;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = 16'h0000; bus.req_wdata = 16'h0000;

    vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'hA5A5, 0,   1'b0, 16'hA5A5};
    vecs[1] = '{1'b1, 16'h4004, 16'h1234, 16'hDEAD, 3,   1'b0, 16'h0000};
    vecs[2] = '{1'b0, 16'hC000, 16'h0000, 16'h7777, 255, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 16'h0020, 16'h0000, 16'h00FF, 15,  1'b0, 16'h00FF};
    vecs[4] = '{1'b0, 16'hC002, 16'h0000, 16'h3C3C, 16,  1'b1, 16'h0000};
    vecs[5] = '{1'b1, 16'h2000, 16'hFFFF, 16'hDEAD, 0,   1'b0, 16'h0000};
    vecs[6] = '{1'b0, 16'h6666, 16'h0000, 16'hBEEF, 7,   1'b0, 16'hBEEF};
    for (int i = 0; i < 4; i++)
      bb[i] = '{1'b0, 16'(16'h8000 + 2 * i), 16'h0000, 16'(16'h1100 * (i + 1)), 0,
                1'b0, 16'(16'h1100 * (i + 1))};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", {31'd0, bus.psel}, 32'd0);
    check("rst_penable", {31'd0, bus.penable}, 32'd0);
    check("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
    check("rst_paddr", {16'd0, bus.paddr}, 32'd0);
    check("rst_pwdata", {16'd0, bus.pwdata}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("req_ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i], acc_dummy);
      bus.req_valid = 1'b0;
      wait_done();
    end

    // req_valid held high across four zero-wait reads.
    for (int i = 0; i < 4; i++) issue(bb[i], acc_t[i]);
    bus.req_valid = 1'b0;
    wait_done();
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc_t[i] - acc_t[i-1], 3);

    // Reset in the middle of a hanging write.
    v = '{1'b1, 16'hA0A0, 16'h5555, 16'h0000, 255, 1'b0, 16'h0000};
    issue(v, acc_dummy);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_penable", {31'd0, bus.penable}, 32'd1);
    reset = 1'b1;
    #1;
    check("req_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    exp_q.delete();
    psel_cnt  = 0;
    model_err = 0;
    @(negedge clk);
    check("rst_mid_psel", {31'd0, bus.psel}, 32'd0);
    check("rst_mid_penable", {31'd0, bus.penable}, 32'd0);
    check("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_mid_err_count", {24'd0, bus.err_count}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("no_rsp_after_rst", {31'd0, bus.rsp_valid}, 32'd0);
    end

    v = '{1'b0, 16'h0030, 16'h0000, 16'h9182, 2, 1'b0, 16'h9182};
    issue(v, acc_dummy);
    bus.req_valid = 1'b0;
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_port.md
Name: apb_master_port

Overview:
APB requester that sits between the CPU core and the shared 16-bit APB bus, directly upstream of the system address decoder and the ROM/RAM/SPI slaves.
- Converts single-beat CPU load/store requests into APB SETUP/ACCESS sequences and drives the CPU-side select (psel) that the decoder qualifies.
- Returns read data with a one-cycle response pulse.
- Aborts with an error on a bounded timeout, since address region 2'b11 selects no slave and never returns pready.

Parameters:
TIMEOUT_CYCLES, 16, number of ACCESS cycles without pready before the transfer is aborted (legal range 1..255).
ERR_CNT_W, 8, width of the saturating timeout counter.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  request accepted when req_valid && req_ready at a clk edge
req_write  input  1  1 = write, 0 = read
req_addr  input  16  transfer address
req_wdata  input  16  write data
rsp_valid  output  1  one-cycle pulse: transfer complete
rsp_rdata  output  16  read data, valid with rsp_valid
rsp_err  output  1  timeout abort, valid with rsp_valid
err_count  output  ERR_CNT_W  saturating count of timeouts
psel  output  1  CPU-side APB select, qualified by the address decoder
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  16  APB address
pwdata  output  16  APB write data
prdata  input  16  APB read data
pready  input  1  APB ready from the selected slave

Behaviour:
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, latch write/addr/wdata; go to SETUP.
  - SETUP: exactly one cycle; psel=1, penable=0; go to ACCESS.
  - ACCESS: psel=1, penable=1.
    - pready=1 at the edge: complete normally; go to IDLE.
    - Otherwise increment the wait counter.
    - Counter reaching TIMEOUT_CYCLES at the edge with pready still 0: abort; go to IDLE.
- Bus outputs are registered. paddr, pwrite and pwdata are held constant from SETUP through the final ACCESS cycle, and retain their last values in IDLE.
- pready and prdata are sampled only in ACCESS. pready is ignored in IDLE and SETUP.
- Normal completion:
  - rsp_valid=1 for exactly one cycle, in the cycle after the pready edge.
  - rsp_err=0.
  - rsp_rdata = prdata sampled at that edge for reads; 16'h0000 for writes.
- Timeout completion:
  - rsp_valid=1, rsp_err=1, rsp_rdata=16'h0000.
  - err_count increments and saturates at all-ones.
- pready=1 in the TIMEOUT_CYCLES-th ACCESS cycle counts as a normal completion; success wins over timeout.
- The wait counter clears on entry to SETUP.
- Latency with zero wait states: accept edge E0, SETUP cycle, ACCESS cycle, pready edge E2; rsp_valid is high in the cycle after E2.
- req_ready is high in the same cycle as rsp_valid, so back-to-back transfers start every 3 cycles minimum.
- req_ready is combinational from state. It is 0 while reset is high and in SETUP and ACCESS.
- Requests arriving while req_ready=0 are not accepted; the CPU must hold req_valid and its request fields.
- Reset values:
  - state=IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - err_count=0.
- Reset mid-transfer: psel and penable are low in the first cycle after the reset edge, no response is issued, and the latched request is discarded.

Test Plan:
1. Read 0x0010 (ROM), slave drives pready=1 in the first ACCESS cycle with prdata=16'hA5A5 -> psel 2 cycles, penable 1 cycle; rsp_valid pulse 3 cycles after accept with rsp_rdata=16'hA5A5, rsp_err=0.
2. Write 0x4004 (RAM) with wdata 16'h1234 and 3 wait states -> paddr, pwdata and pwrite=1 stable for 5 cycles; rsp_valid once with rsp_rdata=16'h0000.
3. Read 0xC000, pready held 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=16'h0000, err_count=1; psel drops the next cycle.
4. pready=1 exactly in the 16th ACCESS cycle with prdata=16'h00FF -> rsp_err=0, rsp_rdata=16'h00FF, err_count unchanged.
5. req_valid held for 4 consecutive reads to 0x8000, 0x8002, 0x8004, 0x8006, all zero-wait -> 4 responses spaced 3 cycles apart, in order, with no overlap of psel between transfers.
6. Assert reset during ACCESS of a write -> no rsp_valid; psel and penable low in the next cycle; req_ready=1 the first cycle after reset deasserts; err_count=0.
